sfr_bank: RTL and testbench



---
 rtl/sfr_pkg.sv | 12 +
 rtl/sfr_cell.sv | 44 ++++
 rtl/sfr_bank.sv | 127 ++++++++++++
 tb/tb_sfr_bank.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/sfr_pkg.sv
// Shared constants for the SFR bank: default geometry and the access-mode encoding.
package sfr_pkg;

    localparam int SFR_WIDTH = 8;
    localparam int SFR_NREG  = 4;

    typedef enum logic {
        ACC_BIT  = 1'b0,
        ACC_BYTE = 1'b1
    } acc_mode_e;

endpackage

// File: rtl/sfr_cell.sv
// One WIDTH-bit special-function register: CPU byte/bit write under mask,
// then hardware clear, then hardware set (set has the final say).
module sfr_cell
    import sfr_pkg::*;
#(
    parameter int               WIDTH = SFR_WIDTH,
    parameter logic [WIDTH-1:0] INITV = '0,
    parameter logic [WIDTH-1:0] WMASK = '1,
    localparam int              BW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_byte,
    input  logic             wr_bit,
    input  logic [BW-1:0]    bit_sel,
    input  logic [WIDTH-1:0] din,
    input  logic             bin,
    input  logic [WIDTH-1:0] hw_set,
    input  logic [WIDTH-1:0] hw_clr,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] val_d;
    logic [WIDTH-1:0] val_q;

    always_comb begin
        val_d = val_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (WMASK[i] && (wr_byte || (wr_bit && (bit_sel == BW'(i))))) begin
                val_d[i] = wr_byte ? din[i] : bin;
            end
            if (hw_clr[i]) val_d[i] = 1'b0;
            if (hw_set[i]) val_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) val_q <= INITV;
        else        val_q <= val_d;
    end

    assign q = val_q;

endmodule

// File: rtl/sfr_bank.sv
// Bank of NREG special-function registers with byte/bit CPU access,
// hardware set/clear per bit, registered read data and an access-error pulse.
module sfr_bank
    import sfr_pkg::*;
#(
    parameter int                    WIDTH   = SFR_WIDTH,
    parameter int                    NREG    = SFR_NREG,
    parameter logic [NREG*WIDTH-1:0] INITV   = {NREG*WIDTH{1'b0}},
    parameter logic [NREG*WIDTH-1:0] WMASK   = {NREG*WIDTH{1'b1}},
    parameter logic [NREG-1:0]       BITADDR = {NREG{1'b1}},
    localparam int                   AW      = $clog2(NREG),
    localparam int                   BW      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  byte_mode,
    input  logic [AW-1:0]         addr,
    input  logic [BW-1:0]         bit_sel,
    input  logic [WIDTH-1:0]      din,
    input  logic                  bin,
    input  logic [NREG*WIDTH-1:0] hw_set,
    input  logic [NREG*WIDTH-1:0] hw_clr,
    output logic [WIDTH-1:0]      dout,
    output logic                  bout,
    output logic                  rvalid,
    output logic                  err,
    output logic [NREG*WIDTH-1:0] cout
);

    logic [WIDTH-1:0] regs [NREG];
    logic [WIDTH-1:0] sel_val;
    logic             sel_bit;
    logic             sel_bitaddr;
    logic             addr_hit;
    logic             is_byte;
    logic             acc_err;
    logic             wr_ok;

    logic [WIDTH-1:0] dout_d, dout_q;
    logic             bout_d, bout_q;
    logic             rvalid_d, rvalid_q;
    logic             err_d, err_q;

    assign is_byte = (acc_mode_e'(byte_mode) == ACC_BYTE);

    // Decode by equality so an address past the last register simply hits nothing.
    always_comb begin
        sel_val     = '0;
        sel_bitaddr = 1'b0;
        addr_hit    = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (addr == AW'(i)) begin
                sel_val     = regs[i];
                sel_bitaddr = BITADDR[i];
                addr_hit    = 1'b1;
            end
        end
    end

    always_comb begin
        sel_bit = 1'b0;
        for (int j = 0; j < WIDTH; j++) begin
            if (bit_sel == BW'(j)) sel_bit = sel_val[j];
        end
    end

    assign acc_err = (wr_en || rd_en) && (!addr_hit || (!is_byte && !sel_bitaddr));
    assign wr_ok   = wr_en && !acc_err;

    for (genvar g = 0; g < NREG; g++) begin : g_cell
        logic hit;
        assign hit = (addr == AW'(g));

        sfr_cell #(
            .WIDTH (WIDTH),
            .INITV (INITV[g*WIDTH +: WIDTH]),
            .WMASK (WMASK[g*WIDTH +: WIDTH])
        ) u_cell (
            .clk     (clk),
            .reset   (reset),
            .wr_byte (wr_ok && hit && is_byte),
            .wr_bit  (wr_ok && hit && !is_byte),
            .bit_sel (bit_sel),
            .din     (din),
            .bin     (bin),
            .hw_set  (hw_set[g*WIDTH +: WIDTH]),
            .hw_clr  (hw_clr[g*WIDTH +: WIDTH]),
            .q       (regs[g])
        );

        assign cout[g*WIDTH +: WIDTH] = regs[g];
    end

    // Read data sampled from the pre-update register value; errored reads return zero.
    always_comb begin
        dout_d   = dout_q;
        bout_d   = bout_q;
        rvalid_d = rd_en;
        err_d    = acc_err;
        if (rd_en) begin
            if (is_byte) dout_d = acc_err ? '0 : sel_val;
            else         bout_d = acc_err ? 1'b0 : sel_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dout_q   <= '0;
            bout_q   <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            dout_q   <= dout_d;
            bout_q   <= bout_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign dout   = dout_q;
    assign bout   = bout_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;

endmodule

// File: tb/tb_sfr_bank.sv
// Directed bench for sfr_bank (5 x 8-bit): stimulus pushes expected read/error
// responses into a queue, a negedge monitor pops and compares them.
module tb_sfr_bank;

    localparam int WIDTH = 8;
    localparam int NREG  = 5;
    localparam logic [39:0] INITV   = 40'h00_12_00_00_A5;
    localparam logic [39:0] WMASK   = 40'hFF_FF_FF_0F_FF;
    localparam logic [4:0]  BITADDR = 5'b01111;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en, rd_en, byte_mode, bin;
    logic [2:0]  addr, bit_sel;
    logic [7:0]  din;
    logic [39:0] hw_set, hw_clr;
    logic [7:0]  dout;
    logic        bout, rvalid, err;
    logic [39:0] cout;

    typedef struct packed {
        logic       rv;
        logic       er;
        logic       bm;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    sfr_bank #(
        .WIDTH(WIDTH), .NREG(NREG), .INITV(INITV), .WMASK(WMASK), .BITADDR(BITADDR)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .byte_mode(byte_mode),
        .addr(addr), .bit_sel(bit_sel), .din(din), .bin(bin),
        .hw_set(hw_set), .hw_clr(hw_clr),
        .dout(dout), .bout(bout), .rvalid(rvalid), .err(err), .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        wr_en = 0; rd_en = 0; byte_mode = 1; addr = 0; bit_sel = 0;
        din = 0; bin = 0; hw_set = '0; hw_clr = '0;
    endtask

    // Drive one access for one edge; the expectation is queued just after the edge.
    task automatic op(input logic w, input logic r, input logic bm, input logic [2:0] a,
                      input logic [2:0] bs, input logic [7:0] d, input logic b,
                      input logic [39:0] hs, input logic [39:0] hc,
                      input logic push, input exp_t e);
        wr_en = w; rd_en = r; byte_mode = bm; addr = a; bit_sel = bs;
        din = d; bin = b; hw_set = hs; hw_clr = hc;
        @(posedge clk);
        if (push) sb.push_back(e);
        #1;
        idle();
    endtask

    localparam exp_t NONE = '0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rvalid", 64'(rvalid), 64'(e.rv));
                chk("err", 64'(err), 64'(e.er));
                if (e.rv) begin
                    if (e.bm) chk("dout", 64'(dout), 64'(e.val));
                    else      chk("bout", 64'(bout), 64'(e.val[0]));
                end
            end else if (rvalid || err) begin
                chk("spurious_rvalid_err", 64'({rvalid, err}), 64'(0));
            end
        end
    end

    initial begin : stim
        idle();
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cout", 64'(cout), 64'(INITV));
        chk("reset_dout", 64'(dout), 64'(0));
        chk("reset_bout", 64'(bout), 64'(0));
        chk("reset_rvalid", 64'(rvalid), 64'(0));
        chk("reset_err", 64'(err), 64'(0));
        reset = 1;
        @(posedge clk); #1;

        // masked byte write, then read back
        op(1, 0, 1, 3'd1, 0, 8'hFF, 0, '0, '0, 0, NONE);
        chk("wmask_cout", 64'(cout), 64'h00_12_00_0F_A5);
        op(0, 1, 1, 3'd1, 0, 0, 0, '0, '0, 1, '{rv:1, er:0, bm:1, val:8'h0F});

        // bit write and bit reads
        op(1, 0, 0, 3'd2, 3'd3, 0, 1, '0, '0, 0, NONE);
        chk("bitwr_cout", 64'(cout), 64'h00_12_08_0F_A5);
        op(0, 1, 0, 3'd2, 3'd3, 0, 0, '0, '0, 1, '{rv:1, er:0, bm:0, val:8'h01});
        op(0, 1, 0, 3'd2, 3'd2, 0, 0, '0, '0, 1, '{rv:1, er:0, bm:0, val:8'h00});
        op(0, 1, 0, 3'd2, 3'd3, 0, 0, '0, '0, 1, '{rv:1, er:0, bm:0, val:8'h01});

        // bit access to a non-bit-addressable register
        op(1, 0, 0, 3'd4, 3'd3, 0, 1, '0, '0, 1, '{rv:0, er:1, bm:0, val:8'h00});
        chk("nobit_wr_cout", 64'(cout), 64'h00_12_08_0F_A5);
        op(0, 1, 0, 3'd4, 3'd3, 0, 0, '0, '0, 1, '{rv:1, er:1, bm:0, val:8'h00});

        // hardware set/clear against CPU writes and each other
        op(1, 0, 1, 3'd0, 0, 8'h00, 0, 40'h80, '0, 0, NONE);
        chk("hwset_vs_wr", 64'(cout), 64'h00_12_08_0F_80);
        op(0, 0, 1, 3'd0, 0, 0, 0, 40'h01, 40'h01, 0, NONE);
        chk("set_beats_clr", 64'(cout), 64'h00_12_08_0F_81);
        op(0, 0, 1, 3'd0, 0, 0, 0, '0, 40'h80, 0, NONE);
        chk("hwclr", 64'(cout), 64'h00_12_08_0F_01);
        op(0, 0, 1, 3'd0, 0, 0, 0, 40'h8000, '0, 0, NONE);
        chk("hwset_readonly", 64'(cout), 64'h00_12_08_8F_01);

        // simultaneous read/write returns old data; next read the new
        op(1, 1, 1, 3'd3, 0, 8'h34, 0, '0, '0, 1, '{rv:1, er:0, bm:1, val:8'h12});
        chk("rdwr_cout", 64'(cout), 64'h00_34_08_8F_01);
        op(0, 1, 1, 3'd3, 0, 0, 0, '0, '0, 1, '{rv:1, er:0, bm:1, val:8'h34});

        op(1, 0, 1, 3'd3, 0, 8'hFF, 0, '0, 40'h0100_0000, 0, NONE);
        chk("hwclr_vs_wr", 64'(cout), 64'h00_FE_08_8F_01);

        // out-of-range address
        op(0, 1, 1, 3'd7, 0, 0, 0, '0, '0, 1, '{rv:1, er:1, bm:1, val:8'h00});
        op(1, 0, 1, 3'd7, 0, 8'h55, 0, '0, '0, 1, '{rv:0, er:1, bm:1, val:8'h00});
        chk("oob_wr_cout", 64'(cout), 64'h00_FE_08_8F_01);

        // bit writes to read-only vs writable bits
        op(1, 0, 0, 3'd1, 3'd7, 0, 0, '0, '0, 0, NONE);
        chk("bitwr_readonly", 64'(cout), 64'h00_FE_08_8F_01);
        op(1, 0, 0, 3'd1, 3'd0, 0, 0, '0, '0, 0, NONE);
        chk("bitwr_clear", 64'(cout), 64'h00_FE_08_8E_01);

        // streaming reads interrupted by reset
        rd_en = 1; byte_mode = 1; addr = 3'd0;
        @(posedge clk); sb.push_back('{rv:1, er:0, bm:1, val:8'h01}); #1;
        addr = 3'd1;
        @(posedge clk); sb.push_back('{rv:1, er:0, bm:1, val:8'h8E}); #1;
        addr = 3'd2;
        reset = 0;
        @(posedge clk); #1;
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        chk("rst_dout", 64'(dout), 64'(0));
        chk("rst_cout", 64'(cout), 64'(INITV));
        reset = 1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
